// File: rtl/reg_bank_banked.sv
// reg_bank_banked: ARMv4 banked register file (USR/FIQ/IRQ/SVC) with two
// prioritised write ports, optional write-to-read bypass and PC auto-increment.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   mode, usr_force       current mode (00 USR, 01 FIQ, 10 IRQ, 11 SVC); usr_force selects USR bank
//   Rn, Rm, Rs            read addresses; Rn_data/Rm_data/Rs_data combinational read data
//   wr0_*                 write port 0 (ALU result)
//   wr1_*                 write port 1 (load/base writeback), wins over wr0 on the same address
//   pc_inc                advance R15 by PC_STEP
//   PC                    raw R15, SP = effective-bank R13
module reg_bank_banked #(
    parameter int unsigned       DATA_W      = 32,
    parameter logic [DATA_W-1:0] SP_RESET    = 32'h0000_8000,
    parameter logic [DATA_W-1:0] PC_RESET    = 32'h0000_0000,
    parameter int unsigned       PC_STEP     = 4,
    parameter int unsigned       PC_READ_OFS = 8,
    parameter bit                BYPASS      = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        mode,
    input  logic              usr_force,
    input  logic [3:0]        Rn,
    input  logic [3:0]        Rm,
    input  logic [3:0]        Rs,
    output logic [DATA_W-1:0] Rn_data,
    output logic [DATA_W-1:0] Rm_data,
    output logic [DATA_W-1:0] Rs_data,
    input  logic              wr0_en,
    input  logic [3:0]        wr0_addr,
    input  logic [DATA_W-1:0] wr0_data,
    input  logic              wr1_en,
    input  logic [3:0]        wr1_addr,
    input  logic [DATA_W-1:0] wr1_data,
    input  logic              pc_inc,
    output logic [DATA_W-1:0] PC,
    output logic [DATA_W-1:0] SP
);
    localparam logic [DATA_W-1:0] STEP = DATA_W'(PC_STEP);
    localparam logic [DATA_W-1:0] OFS  = DATA_W'(PC_READ_OFS);

    // Physical layout: 0-15 USR R0-R15, 16-22 FIQ R8-R14, 23-24 IRQ R13-R14, 25-26 SVC R13-R14
    logic [DATA_W-1:0] regs_q [27];
    logic [DATA_W-1:0] regs_d [27];
    logic [1:0]        em;
    logic [4:0]        w0p, w1p;
    logic [3:0]        ra  [4];
    logic [4:0]        rp  [4];
    logic [DATA_W-1:0] raw [4];
    logic [DATA_W-1:0] rd  [4];

    function automatic logic [4:0] phys(input logic [3:0] a, input logic [1:0] m);
        logic [4:0] x;
        x = {1'b0, a};
        if (a < 4'd8 || a == 4'd15) return x;
        if (a < 4'd13) return (m == 2'b01) ? x + 5'd8 : x;
        return (m == 2'b00) ? x : (m == 2'b01) ? x + 5'd8 : (m == 2'b10) ? x + 5'd10 : x + 5'd12;
    endfunction

    assign em  = usr_force ? 2'b00 : mode;
    assign w0p = phys(wr0_addr, em);
    assign w1p = phys(wr1_addr, em);

    // Slot 3 is the SP tap: a read of R13 through the same bypass path
    assign ra[0] = Rn;
    assign ra[1] = Rm;
    assign ra[2] = Rs;
    assign ra[3] = 4'd13;

    for (genvar g = 0; g < 4; g++) begin : g_rd
        assign rp[g]  = phys(ra[g], em);
        assign raw[g] = (BYPASS && wr1_en && w1p == rp[g]) ? wr1_data :
                        (BYPASS && wr0_en && w0p == rp[g]) ? wr0_data : regs_q[rp[g]];
        assign rd[g]  = (ra[g] == 4'd15) ? raw[g] + OFS : raw[g];
    end

    assign Rn_data = rd[0];
    assign Rm_data = rd[1];
    assign Rs_data = rd[2];
    assign SP      = rd[3];
    assign PC      = regs_q[15];

    // Write order encodes priority: pc_inc < wr0 < wr1
    always_comb begin
        regs_d = regs_q;
        if (pc_inc) regs_d[15] = regs_q[15] + STEP;
        if (wr0_en) regs_d[w0p] = wr0_data;
        if (wr1_en) regs_d[w1p] = wr1_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 27; i++)
                regs_q[i] <= (i == 13 || i == 21 || i == 23 || i == 25) ? SP_RESET :
                             (i == 15) ? PC_RESET : '0;
        end else begin
            regs_q <= regs_d;
        end
    end
endmodule
